uart_rx_frame_ctrl: RTL
=======================

Name: uart_rx_frame_ctrl

Overview:
- Sits directly behind the UART receiver wrapper. Consumes its byte stream (message/isNew) and sequences it into framed packets.
- Frame format: SYNC, LEN, LEN payload bytes, CHECKSUM.
- Writes payload bytes into an external buffer and reports completed or failed frames to the host logic.
- Holds each completed frame until the host acknowledges it, and counts bytes dropped while held.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, largest legal LEN value (1..255).
- TIMEOUT_CYC, 2000, maximum clock cycles allowed between bytes inside a frame.
- ADDR_W, $clog2(MAX_LEN), width of the payload write address.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- byte_valid  input  1  one-cycle pulse; a received byte is present (receiver isNew).
- byte_in  input  8  received byte (receiver message); valid when byte_valid=1.
- frame_ack  input  1  host has consumed the held frame; sampled only in HOLD.
- wr_en  output  1  payload buffer write strobe, one cycle per payload byte.
- wr_addr  output  ADDR_W  payload index 0..LEN-1.
- wr_data  output  8  payload byte.
- frame_done  output  1  one-cycle pulse: good frame received.
- frame_len  output  8  LEN of the last good frame; held until the next good frame.
- frame_err  output  1  one-cycle pulse: frame aborted.
- err_code  output  2  cause of the last error: 1 bad length, 2 checksum, 3 timeout. Held until the next error.
- drop_count  output  8  saturating count of bytes dropped in HOLD.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n=0, async): state goes to IDLE. All outputs are 0, including frame_len, err_code, drop_count, and the internal idx/sum/timer.
- All outputs are registered. Each pulse or write appears the cycle after the byte_valid that causes it.
- States: IDLE, LEN, PAYLOAD, CHECK, HOLD.
- IDLE
  - byte_valid with byte_in==SYNC_BYTE: go to LEN.
  - Any other byte is discarded silently; no error, no count.
- LEN (on byte_valid)
  - byte_in==0 or byte_in>MAX_LEN: frame_err=1, err_code=1, go to IDLE.
  - Otherwise: len<=byte_in, sum<=byte_in, idx<=0, go to PAYLOAD.
- PAYLOAD (on byte_valid)
  - wr_en=1, wr_addr=idx, wr_data=byte_in.
  - sum<=sum+byte_in (mod 256); idx<=idx+1.
  - If idx==len-1, go to CHECK.
  - SYNC_BYTE inside the payload is ordinary data; there is no resync.
- CHECK (on byte_valid)
  - byte_in==sum: frame_done=1, frame_len<=len, go to HOLD.
  - Otherwise: frame_err=1, err_code=2, go to IDLE.
- HOLD
  - byte_valid: byte is dropped; drop_count increments and saturates at 255.
  - frame_ack=1: go to IDLE next cycle.
  - frame_ack and byte_valid in the same cycle: byte is dropped and counted, and the state still goes to IDLE.
  - frame_ack outside HOLD is ignored.
- Timeout (LEN, PAYLOAD and CHECK only)
  - timer clears on entry to these states and on every byte_valid; otherwise it increments.
  - When timer reaches TIMEOUT_CYC-1 with no byte_valid: frame_err=1, err_code=3, go to IDLE.
  - byte_valid in the same cycle as expiry: the byte is processed normally and there is no timeout.
  - No timeout in IDLE or HOLD.
- Partial-frame writes already issued are not retracted on an error; the host trusts only frame_done.
- Reset mid-frame: state is abandoned immediately. No pulse is generated; drop_count clears.
- byte_valid is never asserted on consecutive cycles by the receiver, but the block must still accept back-to-back bytes correctly.

Test Plan:
- Good frame: bytes A5 03 10 20 30 63.
  - Expect wr_en at addr 0/1/2 with data 10/20/30.
  - Then frame_done pulse, frame_len=3, busy=1 until frame_ack.
- Bad length: A5 00 → frame_err, err_code=1, IDLE. Separately, A5 11 (MAX_LEN=16) → err_code=1.
- Checksum error: A5 02 01 02 00 → two writes, then frame_err with err_code=2 and no frame_done.
- Timeout: A5 02 01, then idle TIMEOUT_CYC cycles → frame_err, err_code=3, IDLE.
  - A byte arriving exactly on the expiry cycle: frame continues instead.
- HOLD overrun: good frame, then 300 bytes with no ack → drop_count=255.
  - Then frame_ack together with byte_valid → IDLE.
  - Then A5 01 7F 80 → frame_done with frame_len=1.
- Noise and reset: bytes 00 FF 5A before A5 are ignored. Asserting reset_n=0 mid-PAYLOAD returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: sequences a UART byte stream into SYNC/LEN/payload/CHECKSUM frames.
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   byte_valid, byte_in   received byte strobe and data
//   frame_ack             host has consumed the held frame (used only while holding)
//   wr_en/wr_addr/wr_data payload buffer write port
//   frame_done/frame_len  good-frame pulse and its length (held)
//   frame_err/err_code    abort pulse and cause (1 length, 2 checksum, 3 timeout; held)
//   drop_count            saturating count of bytes dropped while holding a frame
//   busy                  high whenever a frame is in progress or held
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 2000,
  parameter int         ADDR_W      = $clog2(MAX_LEN)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_len,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [7:0]        drop_count,
  output logic              busy
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LEN = 3'd1, S_PAY = 3'd2, S_CHK = 3'd3, S_HOLD = 3'd4;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0]    state;
  logic [7:0]    len, sum, idx;
  logic [TW-1:0] timer;
  logic          in_frame, expire;
  assign in_frame = state == S_LEN || state == S_PAY || state == S_CHK;
  // a byte on the expiry cycle wins over the timeout
  assign expire = in_frame && !byte_valid && timer == TW'(TIMEOUT_CYC - 1);
  assign busy = state != S_IDLE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      len        <= '0;
      sum        <= '0;
      idx        <= '0;
      timer      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      drop_count <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // timer is held at zero outside the timed states, so entry always starts from zero
      timer <= (in_frame && !byte_valid) ? timer + TW'(1) : '0;
      case (state)
        S_IDLE: if (byte_valid && byte_in == SYNC_BYTE) state <= S_LEN;
        S_LEN: if (byte_valid) begin
          if (byte_in == 8'd0 || byte_in > 8'(MAX_LEN)) begin
            frame_err <= 1'b1;
            err_code  <= 2'd1;
            state     <= S_IDLE;
          end else begin
            len   <= byte_in;
            sum   <= byte_in;
            idx   <= '0;
            state <= S_PAY;
          end
        end
        S_PAY: if (byte_valid) begin
          wr_en   <= 1'b1;
          wr_addr <= idx[ADDR_W-1:0];
          wr_data <= byte_in;
          sum     <= sum + byte_in;
          idx     <= idx + 8'd1;
          if (idx == len - 8'd1) state <= S_CHK;
        end
        S_CHK: if (byte_valid) begin
          if (byte_in == sum) begin
            frame_done <= 1'b1;
            frame_len  <= len;
            state      <= S_HOLD;
          end else begin
            frame_err <= 1'b1;
            err_code  <= 2'd2;
            state     <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (byte_valid && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          if (frame_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (expire) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= S_IDLE;
      end
    end
  end
endmodule
